// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control sequencer: steps fetch/decode/execute/memory/writeback and drives datapath controls.
// Optional performance counters (cycle_cnt, instret_cnt) are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] alu_op;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // PC is already incremented; compute the branch target from OldPC
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BEQ:            state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        state_next    = S_FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                PCWrite    = Zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // Jump target was latched into ALUOut during DECODE; OldPC+4 goes to rd next
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
        if (reset) begin
            mem_req       = 1'b0;
            AdrSrc        = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
            ResultSrc     = 2'b10;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b10;
            alu_op        = 2'b00;
        end
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign state_dbg = state_reg;

`ifdef CTRL_PERF_CNT_EN
    logic retire;

    // JAL retires through ALUWB, so it is not listed separately
    assign retire = (state_reg == S_MEMWB) || (state_reg == S_ALUWB) || (state_reg == S_BEQ) ||
                    ((state_reg == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed per-cycle vectors push expected outputs, a negedge monitor compares.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    multicycle_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [21:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_issued = 0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011;
    localparam logic [6:0] S = 7'b0100011, B = 7'b1100011, J = 7'b1101111, X = 7'b0000000;

    // en = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal_instr}
    task automatic vec(input logic rst, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic rdy, input logic [3:0] st, input logic [6:0] en,
                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] imm, input logic [2:0] alu);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        op        = o;
        funct3    = f3;
        funct7b5  = f7;
        Zero      = z;
        mem_ready = rdy;
        e.idx = n_issued;
        e.v   = {st, en, rs, sa, sb, imm, alu};
        exp_q.push_back(e);
        n_issued++;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [21:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {state_dbg, mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal_instr,
                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
                n_vec++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL vec%0d st/en/rs/sa/sb/imm/alu got=%b_%b_%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b_%b_%b",
                             e.idx, got[21:18], got[17:11], got[10:9], got[8:7], got[6:5], got[4:3], got[2:0],
                             e.v[21:18], e.v[17:11], e.v[10:9], e.v[8:7], e.v[6:5], e.v[4:3], e.v[2:0]);
                end else begin
                    $display("vec%0d ok state=%0d", e.idx, got[21:18]);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; op = R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        // reset held three cycles
        repeat (3) vec(1, R, 3'b000, 0, 0, 1, 4'd0, 7'b0000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        // add
        vec(0, R, 3'b000, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        vec(0, R, 3'b000, 0, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        vec(0, R, 3'b000, 0, 0, 1, 4'd6, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
        vec(0, R, 3'b000, 0, 0, 1, 4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        // sub
        vec(0, R, 3'b000, 1, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        vec(0, R, 3'b000, 1, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        vec(0, R, 3'b000, 1, 0, 1, 4'd6, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
        vec(0, R, 3'b000, 1, 0, 1, 4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        // lw with two wait cycles in MEMREAD; mem_ready low in DECODE is ignored
        vec(0, L, 3'b010, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        vec(0, L, 3'b010, 0, 0, 0, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        vec(0, L, 3'b010, 0, 0, 1, 4'd2, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
        vec(0, L, 3'b010, 0, 0, 0, 4'd3, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        vec(0, L, 3'b010, 0, 0, 0, 4'd3, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        vec(0, L, 3'b010, 0, 0, 1, 4'd3, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        vec(0, L, 3'b010, 0, 0, 1, 4'd4, 7'b0000010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
        // sw with one FETCH wait
        vec(0, S, 3'b010, 0, 0, 0, 4'd0, 7'b1000000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 1, 4'd2, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 1, 4'd5, 7'b1100100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
        // beq taken, then not taken
        vec(0, B, 3'b000, 0, 1, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
        vec(0, B, 3'b000, 0, 1, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
        vec(0, B, 3'b000, 0, 1, 1, 4'd9, 7'b0001000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
        vec(0, B, 3'b000, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
        vec(0, B, 3'b000, 0, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
        vec(0, B, 3'b000, 0, 0, 1, 4'd9, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
        // jal
        vec(0, J, 3'b000, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000);
        vec(0, J, 3'b000, 0, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000);
        vec(0, J, 3'b000, 0, 0, 1, 4'd10, 7'b0001000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
        vec(0, J, 3'b000, 0, 0, 1, 4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
        // andi (funct7b5 set but op[5]=0 must not select sub), then ori
        vec(0, I, 3'b111, 1, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        vec(0, I, 3'b111, 1, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        vec(0, I, 3'b111, 1, 0, 1, 4'd7, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010);
        vec(0, I, 3'b111, 1, 0, 1, 4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        vec(0, I, 3'b110, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        vec(0, I, 3'b110, 0, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        vec(0, I, 3'b110, 0, 0, 1, 4'd7, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011);
        vec(0, I, 3'b110, 0, 0, 1, 4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        // slt
        vec(0, R, 3'b010, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        vec(0, R, 3'b010, 0, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        vec(0, R, 3'b010, 0, 0, 1, 4'd6, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101);
        vec(0, R, 3'b010, 0, 0, 1, 4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        // illegal opcode
        vec(0, X, 3'b000, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        vec(0, X, 3'b000, 0, 0, 1, 4'd1, 7'b0000001, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        // sw stalled in MEMWRITE, then reset aborts it
        vec(0, S, 3'b010, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 1, 4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 1, 4'd2, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 0, 4'd5, 7'b1100100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
        vec(1, S, 3'b010, 0, 0, 0, 4'd5, 7'b0000000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
        vec(0, S, 3'b010, 0, 0, 1, 4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
        // give the monitor a bounded window to drain the queue
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain left=%0d required=0", exp_q.size());
            n_bad++;
        end
        if (n_vec != n_issued) begin
            $display("FAIL count checked=%0d required=%0d", n_vec, n_issued);
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
